// File: rtl/raster_tile_scheduler.sv
// rtl/raster_tile_scheduler.sv - walks one tile engine across the screen, streaming every triangle per tile
module raster_tile_scheduler #(
   parameter int BLOCK_SIZE = 5,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int TRI_ADDR_W = 10
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic [TRI_ADDR_W:0]   i_tri_count,
   output logic                  o_tri_rd,
   output logic [TRI_ADDR_W-1:0] o_tri_addr,
   output logic                  o_block_data_in,
   output logic [1:0][9:0]       o_block_location,
   input  logic                  i_block_ready,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [15:0]           o_tile_index
);

   localparam logic [9:0] X_LAST = 10'(SCREEN_W - BLOCK_SIZE);
   localparam logic [9:0] Y_LAST = 10'(SCREEN_H - BLOCK_SIZE);
   localparam logic [9:0] STEP   = 10'(BLOCK_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_DRAIN, S_WAIT_READY, S_ADVANCE, S_FINISH
   } state_t;

   state_t                r_state, w_next;
   logic [TRI_ADDR_W:0]   r_count;
   logic [TRI_ADDR_W-1:0] r_tri_idx;
   logic [9:0]            r_x, r_y;
   logic [15:0]           r_tile;
   logic                  r_data_in;
   logic                  r_zero_done;
   logic                  w_accept;
   logic                  w_last_rd;
   logic                  w_last_tile;

   assign w_accept    = (r_state == S_IDLE) && i_start && (i_tri_count != '0);
   assign w_last_rd   = ({1'b0, r_tri_idx} == (r_count - (TRI_ADDR_W+1)'(1)));
   assign w_last_tile = (r_x == X_LAST) && (r_y == Y_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_accept) w_next = S_ISSUE;
         S_ISSUE:      if (w_last_rd) w_next = S_DRAIN;
         S_DRAIN:      w_next = S_WAIT_READY;
         S_WAIT_READY: if (i_block_ready) w_next = S_ADVANCE;
         S_ADVANCE:    w_next = w_last_tile ? S_FINISH : S_ISSUE;
         S_FINISH:     w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_tri_idx   <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_tile      <= '0;
         r_data_in   <= 1'b0;
         r_zero_done <= 1'b0;
      end else begin
         r_state     <= w_next;
         // Buffer read data lands one cycle after the read, so the strobe trails tri_rd by one.
         r_data_in   <= (r_state == S_ISSUE);
         r_zero_done <= (r_state == S_IDLE) && i_start && (i_tri_count == '0);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_count   <= i_tri_count;
                  r_tri_idx <= '0;
                  r_x       <= '0;
                  r_y       <= '0;
                  r_tile    <= '0;
               end
            end
            S_ISSUE: begin
               if (!w_last_rd) r_tri_idx <= r_tri_idx + 1'b1;
            end
            S_WAIT_READY: begin
               if (i_block_ready && (r_tile != 16'hFFFF)) r_tile <= r_tile + 16'd1;
            end
            S_ADVANCE: begin
               r_tri_idx <= '0;
               if (r_x != X_LAST) begin
                  r_x <= r_x + STEP;
               end else if (r_y != Y_LAST) begin
                  r_x <= '0;
                  r_y <= r_y + STEP;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_tri_rd            = (r_state == S_ISSUE);
   assign o_tri_addr          = r_tri_idx;
   assign o_block_data_in     = r_data_in;
   assign o_block_location[1] = r_x;
   assign o_block_location[0] = r_y;
   assign o_busy              = (r_state != S_IDLE) && (r_state != S_FINISH);
   assign o_done              = (r_state == S_FINISH) || r_zero_done;
   assign o_tile_index        = r_tile;

endmodule

// File: tb/tb_raster_tile_scheduler.sv
// tb/tb_raster_tile_scheduler.sv - directed bench for raster_tile_scheduler on a 2x2-tile and a full-size screen
`timescale 1ns/1ps
module tb_raster_tile_scheduler;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;

   logic            s_start = 1'b0, s_ready = 1'b0;
   logic [10:0]     s_count = '0;
   logic            s_tri_rd, s_data_in, s_busy, s_done;
   logic [9:0]      s_tri_addr;
   logic [1:0][9:0] s_loc;
   logic [15:0]     s_tile;

   logic            d_start = 1'b0, d_ready = 1'b0;
   logic [10:0]     d_count = '0;
   logic            d_tri_rd, d_data_in, d_busy, d_done;
   logic [9:0]      d_tri_addr;
   logic [1:0][9:0] d_loc;
   logic [15:0]     d_tile;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   raster_tile_scheduler #(.BLOCK_SIZE(5), .SCREEN_W(10), .SCREEN_H(10), .TRI_ADDR_W(10)) u_small (
      .i_clock(clk), .i_reset_n(reset_n), .i_start(s_start), .i_tri_count(s_count),
      .o_tri_rd(s_tri_rd), .o_tri_addr(s_tri_addr), .o_block_data_in(s_data_in),
      .o_block_location(s_loc), .i_block_ready(s_ready), .o_busy(s_busy),
      .o_done(s_done), .o_tile_index(s_tile)
   );

   raster_tile_scheduler u_dflt (
      .i_clock(clk), .i_reset_n(reset_n), .i_start(d_start), .i_tri_count(d_count),
      .o_tri_rd(d_tri_rd), .o_tri_addr(d_tri_addr), .o_block_data_in(d_data_in),
      .o_block_location(d_loc), .i_block_ready(d_ready), .o_busy(d_busy),
      .o_done(d_done), .o_tile_index(d_tile)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one 2x2-tile frame; the engine answers rdy_delay cycles after the last data strobe.
   task automatic small_frame(input int cnt, input int rdy_delay, input bit noise, input string nm);
      int ex, ey;
      s_count = 11'(cnt);
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      for (int t = 0; t < 4; t++) begin
         ex = (t % 2) * 5;
         ey = (t / 2) * 5;
         for (int k = 0; k < cnt; k++) begin
            check_eq({nm, "_rd"},   32'(s_tri_rd), 1);
            check_eq({nm, "_addr"}, 32'(s_tri_addr), k);
            check_eq({nm, "_din"},  32'(s_data_in), 32'(k > 0));
            check_eq({nm, "_x"},    32'(s_loc[1]), ex);
            check_eq({nm, "_y"},    32'(s_loc[0]), ey);
            check_eq({nm, "_busy"}, 32'(s_busy), 1);
            if (noise && k == 0) begin
               s_ready = 1'b1;
               s_start = 1'b1;
            end
            step();
            s_ready = 1'b0;
            s_start = 1'b0;
         end
         check_eq({nm, "_drain_rd"},  32'(s_tri_rd), 0);
         check_eq({nm, "_drain_din"}, 32'(s_data_in), 1);
         check_eq({nm, "_drain_done"}, 32'(s_done), 0);
         step();
         for (int j = 1; j < rdy_delay; j++) begin
            check_eq({nm, "_wait_rd"},  32'(s_tri_rd), 0);
            check_eq({nm, "_wait_din"}, 32'(s_data_in), 0);
            check_eq({nm, "_wait_x"},   32'(s_loc[1]), ex);
            check_eq({nm, "_wait_y"},   32'(s_loc[0]), ey);
            step();
         end
         check_eq({nm, "_tile_pre"}, 32'(s_tile), t);
         s_ready = 1'b1;
         step();
         s_ready = 1'b0;
         check_eq({nm, "_tile_post"}, 32'(s_tile), t + 1);
         check_eq({nm, "_adv_rd"},    32'(s_tri_rd), 0);
         step();
      end
      check_eq({nm, "_done"},     32'(s_done), 1);
      check_eq({nm, "_fin_busy"}, 32'(s_busy), 0);
      check_eq({nm, "_fin_x"},    32'(s_loc[1]), 5);
      check_eq({nm, "_fin_y"},    32'(s_loc[0]), 5);
      check_eq({nm, "_fin_tile"}, 32'(s_tile), 4);
      step();
      check_eq({nm, "_done_end"}, 32'(s_done), 0);
      check_eq({nm, "_idle_busy"}, 32'(s_busy), 0);
      check_eq({nm, "_idle_rd"},  32'(s_tri_rd), 0);
      check_eq({nm, "_hold_tile"}, 32'(s_tile), 4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin
      int bad, ex, ey;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rd",   32'(s_tri_rd), 0);
      check_eq("rst_addr", 32'(s_tri_addr), 0);
      check_eq("rst_din",  32'(s_data_in), 0);
      check_eq("rst_loc",  32'(s_loc), 0);
      check_eq("rst_busy", 32'(s_busy), 0);
      check_eq("rst_done", 32'(s_done), 0);
      check_eq("rst_tile", 32'(s_tile), 0);
      check_eq("rst_dflt_busy", 32'(d_busy), 0);
      reset_n = 1'b1;
      step();

      small_frame(3, 4, 1'b0, "t1");

      s_count = 11'd0;
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      check_eq("zero_done", 32'(s_done), 1);
      check_eq("zero_busy", 32'(s_busy), 0);
      check_eq("zero_rd",   32'(s_tri_rd), 0);
      step();
      check_eq("zero_done_end", 32'(s_done), 0);
      check_eq("zero_busy2",    32'(s_busy), 0);
      check_eq("zero_rd2",      32'(s_tri_rd), 0);
      step();

      small_frame(2, 50, 1'b0, "t4");
      small_frame(3, 4, 1'b1, "t6");
      small_frame(1, 1, 1'b0, "c1");

      d_count = 11'd1;
      d_start = 1'b1;
      step();
      d_start = 1'b0;
      bad = 0;
      ex = 0;
      ey = 0;
      for (int t = 0; t < 12288; t++) begin
         if (!(d_tri_rd === 1'b1 && d_tri_addr === 10'd0 && d_data_in === 1'b0 &&
               d_loc[1] === 10'(ex) && d_loc[0] === 10'(ey))) bad++;
         step();
         if (!(d_tri_rd === 1'b0 && d_data_in === 1'b1)) bad++;
         step();
         d_ready = 1'b1;
         step();
         d_ready = 1'b0;
         step();
         ex += 5;
         if (ex == 640) begin
            ex = 0;
            ey += 5;
         end
      end
      check_eq("dflt_bad_tiles", bad, 0);
      check_eq("dflt_done",  32'(d_done), 1);
      check_eq("dflt_x",     32'(d_loc[1]), 635);
      check_eq("dflt_y",     32'(d_loc[0]), 475);
      check_eq("dflt_tile",  32'(d_tile), 12288);
      check_eq("dflt_busy",  32'(d_busy), 0);
      step();
      check_eq("dflt_done_end", 32'(d_done), 0);

      s_count = 11'd3;
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      repeat (3) step();
      step();
      s_ready = 1'b1;
      step();
      s_ready = 1'b0;
      step();
      check_eq("t5_tile2_rd",   32'(s_tri_rd), 1);
      check_eq("t5_tile2_addr", 32'(s_tri_addr), 0);
      check_eq("t5_tile2_x",    32'(s_loc[1]), 5);
      step();
      check_eq("t5_tile2_addr1", 32'(s_tri_addr), 1);
      #1 reset_n = 1'b0;
      #1;
      check_eq("t5_rst_rd",   32'(s_tri_rd), 0);
      check_eq("t5_rst_addr", 32'(s_tri_addr), 0);
      check_eq("t5_rst_din",  32'(s_data_in), 0);
      check_eq("t5_rst_busy", 32'(s_busy), 0);
      check_eq("t5_rst_x",    32'(s_loc[1]), 0);
      check_eq("t5_rst_tile", 32'(s_tile), 0);
      step();
      reset_n = 1'b1;
      step();
      check_eq("t5_idle_rd", 32'(s_tri_rd), 0);
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      check_eq("t5_new_rd",   32'(s_tri_rd), 1);
      check_eq("t5_new_addr", 32'(s_tri_addr), 0);
      check_eq("t5_new_loc",  32'(s_loc), 0);
      check_eq("t5_new_busy", 32'(s_busy), 1);
      step();
      check_eq("t5_new_addr1", 32'(s_tri_addr), 1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
